// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch front end: sequential fetch, req/ack memory handshake, head-of-queue to decode
module fetch_queue #(
  parameter int          DEPTH   = 4,
  parameter logic [31:0] RESETPC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instrF,
  output logic [31:0] pcF,
  output logic [31:0] pcplus4F
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_e;

  state_e        state, stateNext;
  logic [31:0]   fpc, fpcNext, addrNext, targetPc;
  logic          reqNext, push, pop, room, roomAfterPush;
  logic [PW-1:0] rdPtr, wrPtr;
  logic [CW-1:0] count, countAfterPop;
  logic [31:0]   instrMem [DEPTH];
  logic [31:0]   pcMem    [DEPTH];

  assign targetPc      = {redirect_pc[31:2], 2'b00};
  assign pop           = instr_valid & ~stall & ~redirect;
  assign countAfterPop = count - {{(CW-1){1'b0}}, pop};
  assign room          = countAfterPop < CW'(DEPTH);
  assign roomAfterPush = (countAfterPop + CW'(1)) < CW'(DEPTH);

  // Only one request is ever outstanding, so checking room at issue time rules out overflow.
  always_comb begin
    stateNext = state;
    fpcNext   = fpc;
    addrNext  = imem_addr;
    reqNext   = imem_req;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (redirect) begin
          fpcNext = targetPc;
        end else if (room) begin
          addrNext  = fpc;
          reqNext   = 1'b1;
          stateNext = WAIT;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          if (redirect) begin
            fpcNext   = targetPc;
            reqNext   = 1'b0;
            stateNext = IDLE;
          end else begin
            push    = 1'b1;
            fpcNext = fpc + 32'd4;
            if (roomAfterPush) begin
              addrNext = fpc + 32'd4;
            end else begin
              reqNext   = 1'b0;
              stateNext = IDLE;
            end
          end
        end else if (redirect) begin
          fpcNext   = targetPc;
          stateNext = DISCARD;
        end
      end
      DISCARD: begin
        // The stale request cannot be retracted; wait for its ack and throw the data away.
        if (redirect) fpcNext = targetPc;
        if (imem_ack) begin
          reqNext   = 1'b0;
          stateNext = IDLE;
        end
      end
      default: begin
        reqNext   = 1'b0;
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      fpc       <= RESETPC;
      imem_req  <= 1'b0;
      imem_addr <= RESETPC;
      count     <= '0;
      rdPtr     <= '0;
      wrPtr     <= '0;
    end else begin
      state     <= stateNext;
      fpc       <= fpcNext;
      imem_req  <= reqNext;
      imem_addr <= addrNext;
      if (redirect) begin
        count <= '0;
        rdPtr <= '0;
        wrPtr <= '0;
      end else begin
        if (push) wrPtr <= wrPtr + PW'(1);
        if (pop)  rdPtr <= rdPtr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instrMem[wrPtr] <= imem_rdata;
      pcMem[wrPtr]    <= imem_addr;
    end
  end

  assign instr_valid = (count != '0);
  assign instrF      = instr_valid ? instrMem[rdPtr] : 32'd0;
  assign pcF         = instr_valid ? pcMem[rdPtr] : 32'd0;
  assign pcplus4F    = instr_valid ? pcMem[rdPtr] + 32'd4 : 32'd0;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized bench for fetch_queue against a transaction-level queue model
module tb_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;
  localparam logic [31:0] KEY      = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        stall = 1'b0;
  logic        instr_valid;
  logic [31:0] instrF, pcF, pcplus4F;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .RESETPC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
    .instr_valid(instr_valid), .instrF(instrF), .pcF(pcF), .pcplus4F(pcplus4F)
  );

  int checksRun = 0;
  int checksPassed = 0;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checksRun++;
    if (got === exp) checksPassed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Model: the queue holds fetched PCs in order (instruction word is PC^KEY).
  logic [31:0] q[$];
  logic [31:0] expAddr, outAddr;
  bit          outstanding, stale, expReq, tieAck, fired;
  int          memAge, memLat, latMode;

  task automatic modelReset();
    q.delete();
    expAddr     = RESET_PC;
    outstanding = 1'b0;
    stale       = 1'b0;
    expReq      = 1'b0;
    memAge      = 0;
  endtask

  task automatic checkOutputs();
    checkEq("imem_req", imem_req, expReq);
    if (imem_req) begin
      if (!outstanding) begin
        checkEq("imem_addr_new", imem_addr, expAddr);
        outstanding = 1'b1;
        outAddr     = expAddr;
        stale       = 1'b0;
        memAge      = 0;
        memLat      = (latMode < 0) ? int'($urandom_range(0, 3)) : latMode;
      end else begin
        checkEq("imem_addr_hold", imem_addr, outAddr);
      end
    end
    checkEq("instr_valid", instr_valid, q.size() > 0);
    if (q.size() > 0) begin
      checkEq("pcF", pcF, q[0]);
      checkEq("instrF", instrF, q[0] ^ KEY);
      checkEq("pcplus4F", pcplus4F, q[0] + 32'd4);
    end else begin
      checkEq("pcF_empty", pcF, 32'd0);
      checkEq("instrF_empty", instrF, 32'd0);
      checkEq("pcplus4F_empty", pcplus4F, 32'd0);
    end
  endtask

  task automatic updateModel();
    bit hs, staleAck;
    hs = outstanding && imem_ack;
    staleAck = 1'b0;
    if (q.size() > 0 && !stall && !redirect) void'(q.pop_front());
    if (hs) begin
      outstanding = 1'b0;
      memAge = 0;
      if (stale) staleAck = 1'b1;
      else if (!redirect) begin
        q.push_back(outAddr);
        expAddr = outAddr + 32'd4;
      end
      stale = 1'b0;
    end else if (outstanding) begin
      memAge++;
    end
    if (redirect) begin
      q.delete();
      expAddr = {redirect_pc[31:2], 2'b00};
      if (outstanding) stale = 1'b1;
    end
    expReq = outstanding || (!redirect && !staleAck && q.size() < DEPTH);
  endtask

  // redirMode: 0 none, 2 while pending two cycles before ack, 3 together with an ack, 4 random
  task automatic cycle(input bit stl, input int redirMode, input logic [31:0] rp);
    checkOutputs();
    imem_ack    = tieAck ? 1'b1 : (imem_req && memAge >= memLat);
    imem_rdata  = imem_addr ^ KEY;
    stall       = stl;
    redirect_pc = rp;
    case (redirMode)
      2:       redirect = outstanding && memAge == 1 && !imem_ack;
      3:       redirect = outstanding && imem_ack;
      4:       redirect = ($urandom_range(0, 9) == 0);
      default: redirect = 1'b0;
    endcase
    if (redirect) fired = 1'b1;
    @(posedge clk);
    updateModel();
    @(negedge clk);
  endtask

  initial begin
    tieAck = 1'b1;
    latMode = 0;
    memLat = 0;
    modelReset();
    repeat (2) @(negedge clk);
    checkEq("rst_req", imem_req, 1'b0);
    checkEq("rst_addr", imem_addr, RESET_PC);
    checkEq("rst_valid", instr_valid, 1'b0);
    reset = 1'b1;

    // Streaming with ack tied high: address wrap and pointer wrap
    repeat (20) cycle(1'b0, 0, 32'd0);
    // Fill under stall, then drain
    repeat (10) cycle(1'b1, 0, 32'd0);
    checkEq("full_req_low", imem_req, 1'b0);
    repeat (10) cycle(1'b0, 0, 32'd0);

    // Three-cycle memory latency, then redirect while a request is pending
    tieAck = 1'b0;
    latMode = 3;
    repeat (20) cycle(1'b0, 0, 32'd0);
    fired = 1'b0;
    for (int i = 0; i < 12 && !fired; i++) cycle(1'b0, 2, 32'h0000_0403);
    checkEq("redirect_pending_fired", fired, 1'b1);
    repeat (12) cycle(1'b0, 0, 32'd0);

    // Zero-wait memory, redirect coincident with ack
    latMode = 0;
    repeat (6) cycle(1'b0, 0, 32'd0);
    fired = 1'b0;
    for (int i = 0; i < 12 && !fired; i++) cycle(1'b0, 3, 32'h0000_0123);
    checkEq("redirect_ack_fired", fired, 1'b1);
    repeat (8) cycle(1'b0, 0, 32'd0);

    // Random latency, stall and redirects
    latMode = -1;
    repeat (300) cycle($urandom_range(0, 3) == 0, 4, $urandom);

    // Reset while a request is outstanding
    latMode = 3;
    for (int i = 0; i < 12 && !imem_req; i++) cycle(1'b0, 0, 32'd0);
    checkEq("pre_reset_req", imem_req, 1'b1);
    reset = 1'b0;
    imem_ack = 1'b0;
    redirect = 1'b0;
    stall = 1'b0;
    #1;
    checkEq("async_rst_req", imem_req, 1'b0);
    checkEq("async_rst_addr", imem_addr, RESET_PC);
    checkEq("async_rst_valid", instr_valid, 1'b0);
    checkEq("async_rst_pcF", pcF, 32'd0);
    modelReset();
    @(negedge clk);
    reset = 1'b1;
    latMode = -1;
    repeat (40) cycle($urandom_range(0, 3) == 0, 4, $urandom);

    $display("%0d/%0d checks passed", checksPassed, checksRun);
    $finish;
  end
endmodule
